prbs_checker: RTL and testbench
===============================

PRBS_CHECKER -- requirements
Module: prbs_checker

Interface
REQ-001 Parameter WINDOW, default 64: valid bits per lock-monitor window (range 8..1024).
REQ-002 Parameter ERR_THRESH, default 8: errors within one window that force loss of lock (range 1..WINDOW).
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  in_bit carries a stream bit this cycle.
REQ-006 in_bit  input  1  received serial PRBS bit (generator MSB output).
REQ-007 clear_count  input  1  synchronous clear of err_count.
REQ-008 locked  output  1  checker aligned to the incoming sequence.
REQ-009 err_pulse  output  1  one-cycle flag for a mismatched bit.
REQ-010 lock_lost  output  1  one-cycle flag on the LOCKED->SEED transition.
REQ-011 err_count  output  16  saturating count of mismatched bits.

Function
REQ-012 Sequence: 32-bit history h, h[0] = newest bit; predicted next bit p = h[31]^h[21]^h[1]^h[0] (polynomial x^32+x^22+x^2+x+1, matching the team's 32-bit LFSR generator).
REQ-013 Cycles with in_valid=0 change no state, counter, or history; err_pulse and lock_lost read 0 in the following cycle.
REQ-014 FSM states: SEED, LOCKED.
REQ-015 SEED: each valid bit shifts in, h <= {h[30:0], in_bit}; seed counter increments; no error checking.
REQ-016 SEED -> LOCKED on the 32nd valid seed bit, unless the resulting h is all zero; in that case stay in SEED with the seed counter reset to 0 (an all-zero stream never locks).
REQ-017 LOCKED: each valid bit compared with p; h <= {h[30:0], p} (free-running prediction, so one line error gives exactly one count).
REQ-018 Mismatch (in_bit != p while LOCKED) -> err_pulse=1 in the cycle after the sampling edge; err_count increments unless it is already 0xFFFF.
REQ-019 Window: counter of valid bits in LOCKED plus a per-window error counter; both clear when WINDOW bits have been checked and on entry to LOCKED.
REQ-020 When the window error count reaches ERR_THRESH (counting the current bit): next state SEED, seed counter 0, lock_lost=1 for one cycle, locked=0 from the next cycle.
REQ-021 The bit that triggers loss of lock counts in err_count; it does not count as a seed bit.
REQ-022 locked is registered and equals (state == LOCKED); it rises the cycle after the 32nd seed bit is sampled.
REQ-023 clear_count=1 -> err_count=0 next cycle; it takes priority over a same-cycle increment (that error is dropped); err_pulse is unaffected.
REQ-024 Window counters reset only on window wrap or state entry, not on clear_count.

Reset
REQ-025 reset=1 -> state SEED, h=0, seed/window/error counters 0, locked=0, err_pulse=0, lock_lost=0, err_count=0 on the next edge; reset overrides all inputs.
REQ-026 Reset asserted mid-seed or mid-lock discards all progress; after release, 32 new valid bits are needed to lock.

Verification
REQ-027 Generator seeded 0xACE1ACE1, in_valid=1 continuously -> locked=1 in the cycle after bit 32; 10000 further bits give err_count=0 and no err_pulse.
REQ-028 Locked stream, bit 100 after lock inverted -> exactly one err_pulse, err_count=1, locked stays 1.
REQ-029 Locked stream, 8 bits inverted within one 64-bit window -> lock_lost pulse on the 8th, err_count=8; clean bits follow -> relock 32 valid bits later.
REQ-030 All-zero input, 100 valid bits -> locked stays 0, err_count=0.
REQ-031 in_valid toggled 1/0 in a random pattern on a clean stream -> lock after 32 valid bits, zero errors; clear_count on the same cycle as an injected error -> err_count=0.
REQ-032 err_count forced to 0xFFFF by a continuous error stream with ERR_THRESH=WINDOW -> stays 0xFFFF; reset mid-lock -> all outputs 0 next cycle.

Source files
------------

// File: rtl/prbs_checker.sv
// PRBS-32 (x^32+x^22+x^2+x+1) sequence checker: self-seeds from the incoming stream,
// then counts mismatches and drops lock when too many errors land in one window.
module prbs_checker #(
   parameter int WINDOW     = 64,
   parameter int ERR_THRESH = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   input  logic        in_bit,
   input  logic        clear_count,
   output logic        locked,
   output logic        err_pulse,
   output logic        lock_lost,
   output logic [15:0] err_count
);

   localparam int WW = $clog2(WINDOW) + 1;

   typedef enum logic [0:0] {SEED = 1'b0, LOCKED = 1'b1} state_t;

   function automatic logic predict_bit(input logic [31:0] hist);
      return hist[31] ^ hist[21] ^ hist[1] ^ hist[0];
   endfunction

   state_t          state_r, state_s;
   logic [31:0]     h_r, h_s, shift_s;
   logic [4:0]      seed_cnt_r, seed_cnt_s;
   logic [WW-1:0]   win_cnt_r, win_cnt_s;
   logic [WW-1:0]   win_err_r, win_err_s;
   logic [15:0]     err_count_r, err_count_s;
   logic            err_pulse_r, err_pulse_s;
   logic            lock_lost_r, lock_lost_s;
   logic            locked_r;
   logic            pred_s, mismatch_s;

   // Next-state, history, window and error-count logic
   always_comb begin
      state_s     = state_r;
      h_s         = h_r;
      seed_cnt_s  = seed_cnt_r;
      win_cnt_s   = win_cnt_r;
      win_err_s   = win_err_r;
      err_pulse_s = 1'b0;
      lock_lost_s = 1'b0;
      mismatch_s  = 1'b0;
      pred_s      = predict_bit(h_r);
      shift_s     = {h_r[30:0], in_bit};
      if (in_valid) begin
         case (state_r)
            SEED: begin
               h_s = shift_s;
               if (seed_cnt_r == 5'd31) begin
                  seed_cnt_s = 5'd0;
                  // an all-zero history is a fixed point of the LFSR, so never lock on it
                  if (shift_s != 32'd0) begin
                     state_s   = LOCKED;
                     win_cnt_s = '0;
                     win_err_s = '0;
                  end else begin
                     state_s = SEED;
                  end
               end else begin
                  seed_cnt_s = seed_cnt_r + 5'd1;
               end
            end
            LOCKED: begin
               h_s         = {h_r[30:0], pred_s};
               mismatch_s  = (in_bit != pred_s);
               err_pulse_s = mismatch_s;
               if (mismatch_s && ((win_err_r + WW'(1)) == WW'(ERR_THRESH))) begin
                  state_s     = SEED;
                  seed_cnt_s  = 5'd0;
                  lock_lost_s = 1'b1;
                  win_cnt_s   = '0;
                  win_err_s   = '0;
               end else if (win_cnt_r == WW'(WINDOW - 1)) begin
                  win_cnt_s = '0;
                  win_err_s = '0;
               end else begin
                  win_cnt_s = win_cnt_r + WW'(1);
                  win_err_s = win_err_r + WW'(mismatch_s);
               end
            end
            default: begin
               state_s    = SEED;
               seed_cnt_s = 5'd0;
            end
         endcase
      end else begin
         state_s = state_r;
      end
      if (clear_count) begin
         err_count_s = 16'd0;
      end else if (mismatch_s && (err_count_r != 16'hFFFF)) begin
         err_count_s = err_count_r + 16'd1;
      end else begin
         err_count_s = err_count_r;
      end
   end

   // State and output registers with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r     <= SEED;
         h_r         <= 32'd0;
         seed_cnt_r  <= 5'd0;
         win_cnt_r   <= '0;
         win_err_r   <= '0;
         err_count_r <= 16'd0;
         err_pulse_r <= 1'b0;
         lock_lost_r <= 1'b0;
         locked_r    <= 1'b0;
      end else begin
         state_r     <= state_s;
         h_r         <= h_s;
         seed_cnt_r  <= seed_cnt_s;
         win_cnt_r   <= win_cnt_s;
         win_err_r   <= win_err_s;
         err_count_r <= err_count_s;
         err_pulse_r <= err_pulse_s;
         lock_lost_r <= lock_lost_s;
         locked_r    <= (state_s == LOCKED);
      end
   end

   assign locked    = locked_r;
   assign err_pulse = err_pulse_r;
   assign lock_lost = lock_lost_r;
   assign err_count = err_count_r;

endmodule

// File: tb/tb_prbs_checker.sv
// Scoreboard bench for prbs_checker: drivers push expected outputs tagged with a cycle
// number, a negedge monitor pops and compares. Two instances run in parallel.
module tb_prbs_checker;

   typedef struct {
      int cyc;
      int id;
      int kind;   // 0: output values, 1: running pulse totals
      int lck;
      int ep;
      int ll;
      int cnt;
   } exp_t;

   logic        clk;
   logic        rst1, v1, b1, c1;
   logic        rst2, v2, b2, c2;
   logic        locked1, ep1, ll1, locked2, ep2, ll2;
   logic [15:0] cnt1, cnt2;
   logic [31:0] g1, g2;
   int          cyc = 0;
   int          total = 0;
   int          bad = 0;
   int          ep_tot1 = 0, ll_tot1 = 0, ep_tot2 = 0, ll_tot2 = 0;
   exp_t        q1[$];
   exp_t        q2[$];

   prbs_checker dut1 (
      .clk(clk), .reset(rst1), .in_valid(v1), .in_bit(b1), .clear_count(c1),
      .locked(locked1), .err_pulse(ep1), .lock_lost(ll1), .err_count(cnt1)
   );

   prbs_checker #(.WINDOW(1024), .ERR_THRESH(1024)) dut2 (
      .clk(clk), .reset(rst2), .in_valid(v2), .in_bit(b2), .clear_count(c2),
      .locked(locked2), .err_pulse(ep2), .lock_lost(ll2), .err_count(cnt2)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic cmp(input int d, input int id, input string what, input int act, input int want);
      total++;
      if (act != want) begin
         bad++;
         $display("FAIL dut%0d chk%0d %s: got %0d want %0d (cycle %0d)", d, id, what, act, want, cyc);
      end
   endtask

   task automatic check_entry(input int d, input exp_t e, input logic l, input logic ep,
                              input logic ll, input logic [15:0] cnt, input int ept, input int llt);
      if (e.cyc != cyc) begin
         total++;
         bad++;
         $display("FAIL dut%0d chk%0d missed: at cycle %0d want cycle %0d", d, e.id, cyc, e.cyc);
      end else if (e.kind == 0) begin
         cmp(d, e.id, "locked", int'(l), e.lck);
         cmp(d, e.id, "err_pulse", int'(ep), e.ep);
         cmp(d, e.id, "lock_lost", int'(ll), e.ll);
         cmp(d, e.id, "err_count", int'(cnt), e.cnt);
      end else begin
         cmp(d, e.id, "err_pulse_total", ept, e.ep);
         cmp(d, e.id, "lock_lost_total", llt, e.ll);
      end
   endtask

   // Monitor: accumulate pulses, then retire every expectation due this cycle
   always @(negedge clk) begin
      exp_t e;
      if (ep1 === 1'b1) ep_tot1++;
      if (ll1 === 1'b1) ll_tot1++;
      if (ep2 === 1'b1) ep_tot2++;
      if (ll2 === 1'b1) ll_tot2++;
      while (q1.size() > 0 && q1[0].cyc <= cyc) begin
         e = q1.pop_front();
         check_entry(1, e, locked1, ep1, ll1, cnt1, ep_tot1, ll_tot1);
      end
      while (q2.size() > 0 && q2[0].cyc <= cyc) begin
         e = q2.pop_front();
         check_entry(2, e, locked2, ep2, ll2, cnt2, ep_tot2, ll_tot2);
      end
   end

   task automatic push(input int d, input int id, input int kind, input int l,
                       input int ep, input int ll, input int cnt);
      exp_t e;
      e.cyc = cyc; e.id = id; e.kind = kind; e.lck = l; e.ep = ep; e.ll = ll; e.cnt = cnt;
      if (d == 1) q1.push_back(e);
      else q2.push_back(e);
   endtask

   task automatic step1(input logic r, input logic v, input logic b, input logic c);
      rst1 = r; v1 = v; b1 = b; c1 = c;
      @(posedge clk);
      #1;
   endtask

   task automatic step2(input logic r, input logic v, input logic b, input logic c);
      rst2 = r; v2 = v; b2 = b; c2 = c;
      @(posedge clk);
      #1;
   endtask

   task automatic gen1(output logic b);
      b  = g1[31];
      g1 = {g1[30:0], g1[31] ^ g1[21] ^ g1[1] ^ g1[0]};
   endtask

   task automatic gen2(output logic b);
      b  = g2[31];
      g2 = {g2[30:0], g2[31] ^ g2[21] ^ g2[1] ^ g2[0]};
   endtask

   task automatic run1();
      logic        b;
      logic [63:0] pat;
      logic [5:0]  idx;
      int          nv;
      g1 = 32'hACE1ACE1;
      step1(1'b1, 1'b0, 1'b0, 1'b0);
      step1(1'b1, 1'b0, 1'b0, 1'b0);
      push(1, 1, 0, 0, 0, 0, 0);
      for (int i = 1; i <= 32; i++) begin
         gen1(b); step1(1'b0, 1'b1, b, 1'b0);
         if (i == 31) push(1, 2, 0, 0, 0, 0, 0);
         if (i == 32) push(1, 3, 0, 1, 0, 0, 0);
      end
      for (int i = 1; i <= 10000; i++) begin
         gen1(b); step1(1'b0, 1'b1, b, 1'b0);
      end
      push(1, 4, 0, 1, 0, 0, 0);
      push(1, 5, 1, 0, 0, 0, 0);
      // single inverted bit
      for (int i = 1; i <= 101; i++) begin
         gen1(b); step1(1'b0, 1'b1, (i == 100) ? ~b : b, 1'b0);
         if (i == 100) push(1, 6, 0, 1, 1, 0, 1);
         if (i == 101) push(1, 7, 0, 1, 0, 0, 1);
      end
      push(1, 8, 1, 0, 1, 0, 0);
      // reset mid-lock with all other inputs active
      step1(1'b1, 1'b1, 1'b1, 1'b1);
      push(1, 9, 0, 0, 0, 0, 0);
      // reset mid-seed discards seed progress
      for (int i = 1; i <= 20; i++) begin
         gen1(b); step1(1'b0, 1'b1, b, 1'b0);
      end
      step1(1'b1, 1'b0, 1'b0, 1'b0);
      push(1, 10, 0, 0, 0, 0, 0);
      for (int i = 1; i <= 32; i++) begin
         gen1(b); step1(1'b0, 1'b1, b, 1'b0);
         if (i == 31) push(1, 11, 0, 0, 0, 0, 0);
         if (i == 32) push(1, 12, 0, 1, 0, 0, 0);
      end
      // eight errors inside the first window -> loss of lock on the eighth
      for (int i = 1; i <= 16; i++) begin
         gen1(b); step1(1'b0, 1'b1, (i % 2 == 1) ? ~b : b, 1'b0);
         if (i == 13) push(1, 13, 0, 1, 1, 0, 7);
         if (i == 15) push(1, 14, 0, 0, 1, 1, 8);
         if (i == 16) push(1, 15, 0, 0, 0, 0, 8);
      end
      for (int i = 1; i <= 31; i++) begin
         gen1(b); step1(1'b0, 1'b1, b, 1'b0);
         if (i == 30) push(1, 16, 0, 0, 0, 0, 8);
         if (i == 31) push(1, 17, 0, 1, 0, 0, 8);
      end
      push(1, 18, 1, 0, 9, 1, 0);
      // all-zero stream never locks
      step1(1'b1, 1'b0, 1'b0, 1'b0);
      for (int i = 1; i <= 100; i++) begin
         step1(1'b0, 1'b1, 1'b0, 1'b0);
         if (i == 32) push(1, 19, 0, 0, 0, 0, 0);
         if (i == 64) push(1, 20, 0, 0, 0, 0, 0);
         if (i == 100) push(1, 21, 0, 0, 0, 0, 0);
      end
      // gapped valid pattern, then error / clear interplay
      step1(1'b1, 1'b0, 1'b0, 1'b0);
      pat = 64'hB4E1_9A3C_5F06_D2A7;
      idx = 6'd0;
      nv  = 0;
      while (nv < 32) begin
         if (pat[idx]) begin
            gen1(b); nv++;
            step1(1'b0, 1'b1, b, 1'b0);
            if (nv == 31) push(1, 22, 0, 0, 0, 0, 0);
            if (nv == 32) push(1, 23, 0, 1, 0, 0, 0);
         end else begin
            step1(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'b0);
         end
         idx = idx + 6'd1;
      end
      gen1(b); step1(1'b0, 1'b1, ~b, 1'b0);
      push(1, 24, 0, 1, 1, 0, 1);
      step1(1'b0, 1'b0, 1'b1, 1'b0);
      push(1, 25, 0, 1, 0, 0, 1);
      gen1(b); step1(1'b0, 1'b1, ~b, 1'b1);
      push(1, 26, 0, 1, 1, 0, 0);
      gen1(b); step1(1'b0, 1'b1, b, 1'b0);
      push(1, 27, 0, 1, 0, 0, 0);
      for (int i = 0; i < 40; i++) begin
         if (pat[idx]) begin
            gen1(b); step1(1'b0, 1'b1, b, 1'b0);
         end else begin
            step1(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'b0);
         end
         idx = idx + 6'd1;
      end
      push(1, 28, 0, 1, 0, 0, 0);
      push(1, 29, 1, 0, 11, 1, 0);
   endtask

   task automatic run2();
      logic b;
      g2 = 32'hACE1ACE1;
      step2(1'b1, 1'b0, 1'b0, 1'b0);
      step2(1'b1, 1'b0, 1'b0, 1'b0);
      push(2, 101, 0, 0, 0, 0, 0);
      // each round: 32 seed bits, then a full window of inverted bits
      for (int r = 1; r <= 64; r++) begin
         for (int i = 0; i < 32; i++) begin
            gen2(b); step2(1'b0, 1'b1, b, 1'b0);
         end
         if (r == 1) push(2, 102, 0, 1, 0, 0, 0);
         for (int i = 0; i < 1024; i++) begin
            gen2(b); step2(1'b0, 1'b1, ~b, 1'b0);
         end
         if (r == 1) push(2, 103, 0, 0, 1, 1, 1024);
         if (r == 63) push(2, 104, 0, 0, 1, 1, 64512);
         if (r == 64) push(2, 105, 0, 0, 1, 1, 65535);
      end
      for (int i = 0; i < 32; i++) begin
         gen2(b); step2(1'b0, 1'b1, b, 1'b0);
      end
      push(2, 106, 0, 1, 0, 0, 65535);
      for (int i = 0; i < 10; i++) begin
         gen2(b); step2(1'b0, 1'b1, ~b, 1'b0);
      end
      push(2, 107, 0, 1, 1, 0, 65535);
      step2(1'b1, 1'b1, 1'b0, 1'b0);
      push(2, 108, 0, 0, 0, 0, 0);
   endtask

   initial begin
      exp_t e;
      rst1 = 1'b1; v1 = 1'b0; b1 = 1'b0; c1 = 1'b0;
      rst2 = 1'b1; v2 = 1'b0; b2 = 1'b0; c2 = 1'b0;
      g1 = 32'd0; g2 = 32'd0;
      fork
         run1();
         run2();
      join
      repeat (2) @(posedge clk);
      #1;
      while (q1.size() > 0) begin
         e = q1.pop_front();
         total++; bad++;
         $display("FAIL dut1 chk%0d never checked (due cycle %0d)", e.id, e.cyc);
      end
      while (q2.size() > 0) begin
         e = q2.pop_front();
         total++; bad++;
         $display("FAIL dut2 chk%0d never checked (due cycle %0d)", e.id, e.cyc);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
